// File: rtl/uart_debug_ctrl_if.sv
// Signal bundle between the UART debug controller and its environment
// (UART rx/tx byte datapath, instruction memory, MIPS core, register file).
// The controller uses the master modport; the environment uses slave.
interface uart_debug_ctrl_if #(
  parameter int NB_DATA = 8,
  parameter int NB_WORD = 32,
  parameter int NB_ADDR = 8,
  parameter int NB_REG  = 5
);
  // UART receiver side
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_done;
  // UART transmitter side
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_tx_start;
  logic               i_tx_done;
  // Instruction memory write port
  logic               o_imem_we;
  logic [NB_ADDR-1:0] o_imem_addr;
  logic [NB_WORD-1:0] o_imem_data;
  // Core control and observation
  logic               o_cpu_en;
  logic               i_halt;
  logic [NB_WORD-1:0] i_pc;
  logic [NB_REG-1:0]  o_reg_addr;
  logic [NB_WORD-1:0] i_reg_data;
  // Status
  logic               o_busy;

  modport master (
    input  i_rx_data, i_rx_done, i_tx_done, i_halt, i_pc, i_reg_data,
    output o_tx_data, o_tx_start, o_imem_we, o_imem_addr, o_imem_data,
           o_cpu_en, o_reg_addr, o_busy
  );

  modport slave (
    output i_rx_data, i_rx_done, i_tx_done, i_halt, i_pc, i_reg_data,
    input  o_tx_data, o_tx_start, o_imem_we, o_imem_addr, o_imem_data,
           o_cpu_en, o_reg_addr, o_busy
  );
endinterface

// File: rtl/uart_debug_ctrl.sv
// Command sequencer between the UART byte datapath and the MIPS core.
// Decodes host commands (LOAD/RUN/STEP/DUMP), assembles 32-bit words into
// instruction memory, gates the core clock enable and streams PC plus the
// register file back to the host. One FSM owns both UART directions.
module uart_debug_ctrl #(
  parameter int NB_DATA = 8,
  parameter int NB_WORD = 32,
  parameter int NB_ADDR = 8,
  parameter int NB_REG  = 5,
  parameter int N_REGS  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  uart_debug_ctrl_if.master     bus
);

  localparam logic [NB_DATA-1:0] CMD_LOAD = NB_DATA'(8'h01);
  localparam logic [NB_DATA-1:0] CMD_RUN  = NB_DATA'(8'h02);
  localparam logic [NB_DATA-1:0] CMD_STEP = NB_DATA'(8'h03);
  localparam logic [NB_DATA-1:0] CMD_DUMP = NB_DATA'(8'h04);
  localparam logic [NB_DATA-1:0] RSP_ACK  = NB_DATA'(8'h06);
  localparam logic [NB_DATA-1:0] RSP_NAK  = NB_DATA'(8'h15);
  localparam logic [NB_REG-1:0]  LAST_REG = NB_REG'(N_REGS - 1);

  typedef enum logic [3:0] {
    IDLE, GET_CNT, GET_BYTE, WR_MEM, RUN, STEP,
    DUMP_PC, DUMP_RD, DUMP_CAP, TX_BYTE, TX_WAIT, SEND_RESP
  } state_t;

  state_t             state_q,     state_d;
  state_t             after_q,     after_d;      // where to go once the current tx word is sent
  logic [NB_DATA-1:0] tx_data_q,   tx_data_d;
  logic               tx_start_q,  tx_start_d;
  logic               imem_we_q,   imem_we_d;
  logic [NB_ADDR-1:0] imem_addr_q, imem_addr_d;
  logic [NB_WORD-1:0] asm_q,       asm_d;        // rx word assembly, LSB byte first
  logic               cpu_en_q,    cpu_en_d;
  logic [NB_REG-1:0]  reg_addr_q,  reg_addr_d;
  logic [NB_ADDR-1:0] ptr_q,       ptr_d;        // next imem word address for LOAD
  logic [NB_DATA-1:0] word_cnt_q,  word_cnt_d;   // words still to receive
  logic [1:0]         byte_cnt_q,  byte_cnt_d;   // rx byte position within a word
  logic [1:0]         tx_cnt_q,    tx_cnt_d;     // tx byte position within a word
  logic [NB_WORD-1:0] shift_q,     shift_d;      // tx word, shifted out LSB first

  // State and output registers; reset aborts everything and clears all outputs.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= IDLE;
      after_q     <= IDLE;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      imem_we_q   <= 1'b0;
      imem_addr_q <= '0;
      asm_q       <= '0;
      cpu_en_q    <= 1'b0;
      reg_addr_q  <= '0;
      ptr_q       <= '0;
      word_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      tx_cnt_q    <= '0;
      shift_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      after_q     <= after_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      imem_we_q   <= imem_we_d;
      imem_addr_q <= imem_addr_d;
      asm_q       <= asm_d;
      cpu_en_q    <= cpu_en_d;
      reg_addr_q  <= reg_addr_d;
      ptr_q       <= ptr_d;
      word_cnt_q  <= word_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      tx_cnt_q    <= tx_cnt_d;
      shift_q     <= shift_d;
    end
  end

  // Next-state and next-output decode for the command sequencer.
  always_comb begin
    // NOTE: every _d gets its hold value first, so no path can infer a latch.
    state_d     = state_q;
    after_d     = after_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    imem_we_d   = 1'b0;
    imem_addr_d = imem_addr_q;
    asm_d       = asm_q;
    cpu_en_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    ptr_d       = ptr_q;
    word_cnt_d  = word_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    tx_cnt_d    = tx_cnt_q;
    shift_d     = shift_q;

    unique case (state_q)
      IDLE: begin
        if (bus.i_rx_done) begin
          case (bus.i_rx_data)
            CMD_LOAD: begin
              ptr_d   = '0;
              state_d = GET_CNT;
            end
            CMD_RUN: begin
              // A core already halted never gets enabled.
              if (bus.i_halt) begin
                state_d = DUMP_PC;
              end else begin
                cpu_en_d = 1'b1;
                state_d  = RUN;
              end
            end
            CMD_STEP: begin
              cpu_en_d = 1'b1;
              state_d  = STEP;
            end
            CMD_DUMP: state_d = DUMP_PC;
            default: begin
              shift_d = NB_WORD'(RSP_NAK);
              state_d = SEND_RESP;
            end
          endcase
        end
      end

      GET_CNT: begin
        if (bus.i_rx_done) begin
          word_cnt_d = bus.i_rx_data;
          byte_cnt_d = '0;
          if (bus.i_rx_data == '0) begin
            shift_d = NB_WORD'(RSP_ACK);
            state_d = SEND_RESP;
          end else begin
            state_d = GET_BYTE;
          end
        end
      end

      GET_BYTE: begin
        if (bus.i_rx_done) begin
          asm_d      = {bus.i_rx_data, asm_q[NB_WORD-1:NB_DATA]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            imem_we_d   = 1'b1;
            imem_addr_d = ptr_q;
            state_d     = WR_MEM;
          end
        end
      end

      WR_MEM: begin
        // Pointer wraps naturally at 2^NB_ADDR.
        ptr_d      = ptr_q + NB_ADDR'(1);
        word_cnt_d = word_cnt_q - NB_DATA'(1);
        if (word_cnt_q == NB_DATA'(1)) begin
          shift_d = NB_WORD'(RSP_ACK);
          state_d = SEND_RESP;
        end else begin
          state_d = GET_BYTE;
        end
      end

      RUN: begin
        if (bus.i_halt) begin
          state_d = DUMP_PC;
        end else begin
          cpu_en_d = 1'b1;
        end
      end

      STEP: state_d = DUMP_PC;

      DUMP_PC: begin
        shift_d    = bus.i_pc;
        tx_cnt_d   = '0;
        reg_addr_d = '0;
        after_d    = DUMP_RD;
        state_d    = TX_BYTE;
      end

      // Register file answers one cycle after the address is presented.
      DUMP_RD: state_d = DUMP_CAP;

      DUMP_CAP: begin
        shift_d  = bus.i_reg_data;
        tx_cnt_d = '0;
        if (reg_addr_q == LAST_REG) begin
          after_d = IDLE;
        end else begin
          after_d    = DUMP_RD;
          reg_addr_d = reg_addr_q + NB_REG'(1);
        end
        state_d = TX_BYTE;
      end

      TX_BYTE: begin
        tx_start_d = 1'b1;
        tx_data_d  = shift_q[NB_DATA-1:0];
        shift_d    = shift_q >> NB_DATA;
        state_d    = TX_WAIT;
      end

      TX_WAIT: begin
        // Returning through TX_BYTE guarantees one idle cycle after tx_done.
        if (bus.i_tx_done) begin
          if (tx_cnt_q == 2'd3) begin
            state_d = after_q;
          end else begin
            tx_cnt_d = tx_cnt_q + 2'd1;
            state_d  = TX_BYTE;
          end
        end
      end

      SEND_RESP: begin
        // Single-byte response: start at the last byte slot of the word.
        tx_cnt_d = 2'd3;
        after_d  = IDLE;
        state_d  = TX_BYTE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.o_tx_data   = tx_data_q;
  assign bus.o_tx_start  = tx_start_q;
  assign bus.o_imem_we   = imem_we_q;
  assign bus.o_imem_addr = imem_addr_q;
  assign bus.o_imem_data = asm_q;
  assign bus.o_cpu_en    = cpu_en_q;
  assign bus.o_reg_addr  = reg_addr_q;
  assign bus.o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_debug_ctrl.sv
// Self-checking bench for uart_debug_ctrl: command table, hand-written
// corner sequences and randomized commands checked against a byte-level
// reference model of the host protocol.
module tb_uart_debug_ctrl;

  localparam int NB_DATA = 8;
  localparam int NB_WORD = 32;
  localparam int NB_ADDR = 4;
  localparam int NB_REG  = 5;
  localparam int N_REGS  = 32;
  localparam int N_DUMP  = 4 * (1 + N_REGS);

  logic i_clk;
  logic i_reset;

  uart_debug_ctrl_if #(.NB_DATA(NB_DATA), .NB_WORD(NB_WORD), .NB_ADDR(NB_ADDR), .NB_REG(NB_REG)) bus ();

  uart_debug_ctrl #(
    .NB_DATA(NB_DATA), .NB_WORD(NB_WORD), .NB_ADDR(NB_ADDR), .NB_REG(NB_REG), .N_REGS(N_REGS)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Logs filled by the monitor, expectations filled by the model.
  logic [7:0]            tx_log[$];
  logic [NB_ADDR+31:0]   wr_log[$];
  logic [7:0]            exp_tx[$];
  logic [NB_ADDR+31:0]   exp_wr[$];
  int                    cpu_en_cnt = 0;
  int                    proto_err  = 0;
  int                    cyc        = 0;
  logic [31:0]           load_words[256];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.o_imem_we, bus.o_imem_addr, bus.o_imem_data, bus.o_cpu_en,
                bus.o_tx_start, bus.o_tx_data, bus.o_reg_addr, bus.o_busy});
  endfunction

  // Register file model: word r holds r*0x01010101, read with one-cycle latency.
  initial forever begin
    @(posedge i_clk);
    bus.i_reg_data <= {4{3'b000, bus.o_reg_addr}};
  end

  // UART transmitter model plus output monitor, all sampled on the falling edge.
  initial begin
    bit tx_pending = 0;
    int tx_delay   = 0;
    int last_done  = -10;
    forever begin
      @(negedge i_clk);
      cyc++;
      bus.i_tx_done = 1'b0;
      if (!i_reset) tx_pending = 0;
      if (tx_pending) begin
        if (bus.o_tx_data !== tx_log[$]) proto_err++;
        if (tx_delay == 0) begin
          bus.i_tx_done = 1'b1;
          tx_pending    = 0;
          last_done     = cyc;
        end else begin
          tx_delay--;
        end
      end
      if (bus.o_tx_start === 1'b1) begin
        tx_log.push_back(bus.o_tx_data);
        if (tx_pending) proto_err++;
        if (cyc == last_done + 1) proto_err++;
        tx_pending = 1;
        tx_delay   = $urandom_range(1, 4);
      end
      if (bus.o_imem_we === 1'b1) wr_log.push_back({bus.o_imem_addr, bus.o_imem_data});
      if (bus.o_cpu_en === 1'b1) cpu_en_cnt++;
    end
  end

  // Expected k-th byte of a dump stream: PC word, then registers, LSB first.
  function automatic logic [7:0] dump_byte(input logic [31:0] pc, input int k);
    logic [31:0] w;
    if (k < 4) w = pc;
    else       w = 32'((k - 4) / 4) * 32'h0101_0101;
    return w[8*(k%4) +: 8];
  endfunction

  task automatic push_dump(input logic [31:0] pc);
    for (int k = 0; k < N_DUMP; k++) exp_tx.push_back(dump_byte(pc, k));
  endtask

  task automatic clear_logs();
    tx_log.delete();
    wr_log.delete();
    exp_tx.delete();
    exp_wr.delete();
    cpu_en_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge i_clk);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    @(negedge i_clk);
    bus.i_rx_done = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    @(negedge i_clk);
    while (bus.o_busy === 1'b1 && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    check({name, "_idle"}, 64'(bus.o_busy), 64'd0);
  endtask

  // LOAD model: pointer restarts at 0, wraps at 2^NB_ADDR, one ACK at the end.
  task automatic do_load(input int n);
    send_byte(8'h01);
    send_byte(8'(n));
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 4; b++) send_byte(load_words[i][8*b +: 8]);
      exp_wr.push_back({NB_ADDR'(i % (1 << NB_ADDR)), load_words[i]});
    end
    exp_tx.push_back(8'h06);
  endtask

  task automatic compare(input string name, input int exp_cpu);
    int bad;
    check({name, "_ntx"}, 64'(tx_log.size()), 64'(exp_tx.size()));
    bad = 0;
    for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
      if (tx_log[i] !== exp_tx[i]) bad++;
    check({name, "_txbad"}, 64'(bad), 64'd0);
    check({name, "_nwr"}, 64'(wr_log.size()), 64'(exp_wr.size()));
    bad = 0;
    for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
      if (wr_log[i] !== exp_wr[i]) bad++;
    check({name, "_wrbad"}, 64'(bad), 64'd0);
    check({name, "_cpuen"}, 64'(cpu_en_cnt), 64'(exp_cpu));
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] pc;
    logic        halt;
    int          exp_cpu;
    int          exp_ntx;
    logic [7:0]  exp_tx0;
    logic        is_dump;
  } vec_t;

  localparam int NV = 8;
  vec_t tab[NV];

  initial begin
    int n;
    logic [7:0] b;
    logic [31:0] pc;

    tab[0] = '{8'h7F, 32'h0,          1'b0, 0, 1,      8'h15, 1'b0};
    tab[1] = '{8'h00, 32'h0,          1'b0, 0, 1,      8'h15, 1'b0};
    tab[2] = '{8'hFF, 32'h0,          1'b0, 0, 1,      8'h15, 1'b0};
    tab[3] = '{8'h05, 32'h0,          1'b1, 0, 1,      8'h15, 1'b0};
    tab[4] = '{8'h03, 32'h0000_0010,  1'b0, 1, N_DUMP, 8'h10, 1'b1};
    tab[5] = '{8'h03, 32'hCAFE_F00D,  1'b1, 1, N_DUMP, 8'h0D, 1'b1};
    tab[6] = '{8'h04, 32'h89AB_CDEF,  1'b0, 0, N_DUMP, 8'hEF, 1'b1};
    tab[7] = '{8'h02, 32'h0040_0000,  1'b1, 0, N_DUMP, 8'h00, 1'b1};

    bus.i_rx_data = '0;
    bus.i_rx_done = 1'b0;
    bus.i_halt    = 1'b0;
    bus.i_pc      = '0;
    i_reset       = 1'b0;
    repeat (3) @(negedge i_clk);
    check("reset_outputs", outs(), 64'd0);
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);

    // Two-word LOAD from the host protocol example.
    clear_logs();
    load_words[0] = 32'h1234_5678;
    load_words[1] = 32'hDEAD_BEEF;
    do_load(2);
    wait_idle("load2", 200);
    compare("load2", 0);

    // Empty LOAD still acknowledges.
    clear_logs();
    do_load(0);
    wait_idle("load0", 200);
    compare("load0", 0);

    // Command table: NAKs, STEP, DUMP, RUN with core already halted.
    for (int v = 0; v < NV; v++) begin
      clear_logs();
      bus.i_pc   = tab[v].pc;
      bus.i_halt = tab[v].halt;
      if (tab[v].is_dump) push_dump(tab[v].pc);
      else                exp_tx.push_back(8'h15);
      send_byte(tab[v].cmd);
      wait_idle($sformatf("vec%0d", v), 5000);
      check($sformatf("vec%0d_tx0", v), 64'(tx_log.size() > 0 ? tx_log[0] : 8'hxx), 64'(tab[v].exp_tx0));
      check($sformatf("vec%0d_count", v), 64'(tx_log.size()), 64'(tab[v].exp_ntx));
      compare($sformatf("vec%0d", v), tab[v].exp_cpu);
      bus.i_halt = 1'b0;
    end

    // RUN for 50 enabled cycles, then halt.
    clear_logs();
    bus.i_halt = 1'b0;
    bus.i_pc   = 32'h0000_0100;
    push_dump(32'h0000_0100);
    send_byte(8'h02);
    n = 0;
    while (cpu_en_cnt < 50 && n < 1000) begin
      @(negedge i_clk);
      #1;
      n++;
    end
    bus.i_halt = 1'b1;
    wait_idle("run50", 5000);
    compare("run50", 50);
    bus.i_halt = 1'b0;

    // Bytes arriving during a DUMP are dropped.
    clear_logs();
    bus.i_pc = 32'h1357_9BDF;
    push_dump(32'h1357_9BDF);
    send_byte(8'h04);
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(1, 6)) @(negedge i_clk);
      if (bus.o_busy === 1'b1) begin
        bus.i_rx_data = 8'($urandom_range(1, 4));
        bus.i_rx_done = 1'b1;
        @(negedge i_clk);
        bus.i_rx_done = 1'b0;
      end
    end
    wait_idle("dump_inject", 5000);
    compare("dump_inject", 0);
    clear_logs();
    push_dump(32'h1357_9BDF);
    send_byte(8'h04);
    wait_idle("dump_again", 5000);
    compare("dump_again", 0);

    // 255-word LOAD: address wraps from 2^NB_ADDR-1 back to 0.
    clear_logs();
    for (int i = 0; i < 256; i++) load_words[i] = $urandom;
    do_load(255);
    wait_idle("load255", 200);
    compare("load255", 0);

    // Reset after two bytes of a word: asynchronous clear, nothing written or sent.
    clear_logs();
    load_words[0] = 32'hA5C3_2211;
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    check("load_busy_before_rst", 64'(bus.o_busy), 64'd1);
    @(posedge i_clk);
    #2 i_reset = 1'b0;
    #1 check("rst_async_load", outs(), 64'd0);
    repeat (2) @(negedge i_clk);
    i_reset = 1'b1;
    repeat (10) @(negedge i_clk);
    check("rst_load_nwr", 64'(wr_log.size()), 64'd0);
    check("rst_load_ntx", 64'(tx_log.size()), 64'd0);

    // Reset while the core is running: enable drops without a clock edge.
    clear_logs();
    bus.i_halt = 1'b0;
    send_byte(8'h02);
    repeat (3) @(negedge i_clk);
    check("run_cpu_en_on", 64'(bus.o_cpu_en), 64'd1);
    @(posedge i_clk);
    #2 i_reset = 1'b0;
    #1 check("rst_async_run", outs(), 64'd0);
    repeat (2) @(negedge i_clk);
    i_reset = 1'b1;
    repeat (10) @(negedge i_clk);
    check("rst_run_ntx", 64'(tx_log.size()), 64'd0);

    // Randomized command mix against the protocol model.
    for (int t = 0; t < 20; t++) begin
      clear_logs();
      case ($urandom_range(0, 3))
        0: begin
          n = $urandom_range(0, 6);
          for (int i = 0; i < n; i++) load_words[i] = $urandom;
          do_load(n);
          wait_idle($sformatf("rnd%0d_load", t), 500);
          compare($sformatf("rnd%0d_load", t), 0);
        end
        1: begin
          do b = 8'($urandom_range(0, 255)); while (b inside {[8'h01:8'h04]});
          exp_tx.push_back(8'h15);
          send_byte(b);
          wait_idle($sformatf("rnd%0d_nak", t), 500);
          compare($sformatf("rnd%0d_nak", t), 0);
        end
        2: begin
          pc = $urandom;
          bus.i_pc = pc;
          push_dump(pc);
          send_byte(8'h04);
          wait_idle($sformatf("rnd%0d_dump", t), 5000);
          compare($sformatf("rnd%0d_dump", t), 0);
        end
        default: begin
          pc = $urandom;
          bus.i_pc   = pc;
          bus.i_halt = 1'($urandom_range(0, 1));
          push_dump(pc);
          send_byte(8'h03);
          wait_idle($sformatf("rnd%0d_step", t), 5000);
          compare($sformatf("rnd%0d_step", t), 1);
          bus.i_halt = 1'b0;
        end
      endcase
    end

    check("tx_protocol", 64'(proto_err), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_debug_ctrl.md
Name: uart_debug_ctrl

Overview:
Command sequencer between the UART byte datapath (rx/tx with baud tick) and the MIPS core. It decodes host command bytes from the UART receiver, loads 32-bit instruction words into instruction memory, and gates the core clock-enable for run and single-step. It streams PC and register-file contents back through the UART transmitter. It replaces ad-hoc byte assembly and buffering with one FSM that owns both UART directions.

Parameters:
NB_DATA, 8, UART byte width
NB_WORD, 32, instruction/register word width (fixed 4 bytes)
NB_ADDR, 8, instruction memory word-address width
NB_REG, 5, register-file address width
N_REGS, 32, registers dumped (1..2^NB_REG)

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous reset, active-low (0 = reset)
i_rx_data  in  NB_DATA  received byte, valid when i_rx_done=1
i_rx_done  in  1  one-cycle pulse per received byte
o_tx_data  out  NB_DATA  byte to transmit, stable from o_tx_start until i_tx_done
o_tx_start  out  1  one-cycle pulse starting a transmission
i_tx_done  in  1  one-cycle pulse when transmitter finished the stop bit
o_imem_we  out  1  instruction memory write strobe (one cycle per word)
o_imem_addr  out  NB_ADDR  instruction memory word address
o_imem_data  out  NB_WORD  instruction word to write
o_cpu_en  out  1  core clock enable
i_halt  in  1  core reached halt instruction (level)
i_pc  in  NB_WORD  core program counter
o_reg_addr  out  NB_REG  register-file read address
i_reg_data  in  NB_WORD  register data, valid 1 cycle after o_reg_addr
o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (i_reset=0, async): state IDLE; all outputs 0; load address pointer 0; byte counters 0.
- Commands (byte received in IDLE): 0x01 LOAD, 0x02 RUN, 0x03 STEP, 0x04 DUMP; any other -> send NAK 0x15, back to IDLE.
- LOAD: next rx byte = word count N (0..255). N=0 -> send ACK 0x06. Else receive 4N bytes, LSB first, into a shift/assembly register. After each 4th byte: o_imem_data=word, o_imem_addr=pointer, o_imem_we=1 for exactly one cycle (cycle after the 4th i_rx_done), then pointer+1. Pointer wraps 2^NB_ADDR-1 -> 0. After the N-th word send ACK 0x06. Pointer resets to 0 at each LOAD command (not per word).
- RUN: o_cpu_en=1 starting cycle after the command byte, held until i_halt=1 is sampled. o_cpu_en drops the same cycle i_halt is seen (registered: low next edge), then DUMP. If i_halt already 1 on entry, o_cpu_en never asserts; go directly to DUMP.
- STEP: o_cpu_en=1 for exactly one cycle, then DUMP (regardless of i_halt).
- DUMP: latch i_pc on entry. Send PC as 4 bytes LSB first, then for r=0..N_REGS-1: drive o_reg_addr=r, capture i_reg_data next cycle, send 4 bytes LSB first. Total 4*(1+N_REGS) bytes (132 default). No trailing ACK. Return to IDLE.
- TX handshake: o_tx_start pulses once per byte with o_tx_data valid. Controller waits for i_tx_done before the next o_tx_start. Minimum 1 idle cycle between i_tx_done and next start. Never two starts without an intervening i_tx_done.
- RX during RUN/STEP/DUMP/ACK/NAK transmission: byte silently dropped, no state change.
- i_rx_done and i_tx_done in the same cycle are both honoured.
- FSM states: IDLE, GET_CNT, GET_BYTE, WR_MEM, RUN, STEP, DUMP_PC, DUMP_RD, DUMP_CAP, TX_BYTE, TX_WAIT, SEND_RESP.
- Reset asserted mid-operation: immediate abort to IDLE. o_cpu_en and o_imem_we go 0 asynchronously. Partial word discarded. No response sent.
- No timeout: a stalled LOAD waits indefinitely for bytes.

Test Plan:
- Reset then rx 0x01,0x02,0x78,0x56,0x34,0x12,0xEF,0xBE,0xAD,0xDE -> imem writes (addr0, 0x12345678) and (addr1, 0xDEADBEEF), one-cycle we each; tx 0x06 exactly once.
- rx 0x01,0x00 -> no imem write; tx 0x06. rx 0x7F -> tx 0x15; o_busy back to 0 after i_tx_done.
- rx 0x03 with i_pc=0x00000010, reg[r]=r*0x01010101 -> o_cpu_en high exactly 1 cycle; 132 tx bytes starting 0x10,0x00,0x00,0x00,0x00,0x00,0x00,0x00,0x01,0x01,0x01,0x01; one start per done.
- rx 0x02, assert i_halt after 50 cycles -> o_cpu_en high 50 cycles then low; 132-byte dump follows. Repeat with i_halt=1 on entry -> o_cpu_en never high.
- Bytes injected during a DUMP -> dump content and count unchanged; controller returns to IDLE and accepts a next 0x04.
- LOAD with N=255 and NB_ADDR=4 -> addresses wrap 15->0; i_reset pulsed low after 2 bytes of a word -> all outputs 0 immediately; no we, no tx.
